// File: rtl/stepper_pulse_gen.sv
// Step/direction pulse generator for one stepper axis.
// Issues a counted burst of STEP pulses with optional linear accel/decel and abort.
module stepper_pulse_gen #(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned DIR_SETUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] step_count,
  input  logic [DIV_W-1:0] start_half,
  input  logic [DIV_W-1:0] target_half,
  input  logic [DIV_W-1:0] ramp_dec,
  input  logic             dir_in,
  input  logic             abort,
  output logic             step,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] steps_done
);

  localparam int unsigned SET_W = (DIR_SETUP < 2) ? 1 : $clog2(DIR_SETUP);
  localparam logic [SET_W-1:0] SETUP_LAST = SET_W'(DIR_SETUP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_FIN
  } state_t;

  state_t           state, state_nxt;
  logic [SET_W-1:0] setup_cnt, setup_cnt_nxt;
  logic [DIV_W-1:0] phase_cnt, phase_cnt_nxt;
  logic [DIV_W-1:0] cur_half, cur_half_nxt;
  logic [CNT_W-1:0] ramp_cnt, ramp_cnt_nxt;
  logic [CNT_W-1:0] cnt_lat, cnt_lat_nxt;
  logic [DIV_W-1:0] start_lat, start_lat_nxt;
  logic [DIV_W-1:0] target_lat, target_lat_nxt;
  logic [DIV_W-1:0] ramp_lat, ramp_lat_nxt;
  logic             abort_pend, abort_pend_nxt;
  logic             step_nxt, dir_nxt, busy_nxt, done_nxt, aborted_nxt;
  logic [CNT_W-1:0] steps_done_nxt;

  // Launch-time clamping of the half-period fields
  logic [DIV_W-1:0] sh_clamp_c, th_raw_c, th_clamp_c;
  always_comb begin
    sh_clamp_c = (start_half == '0) ? DIV_W'(1) : start_half;
    th_raw_c   = (target_half == '0) ? DIV_W'(1) : target_half;
    th_clamp_c = (th_raw_c > sh_clamp_c) ? sh_clamp_c : th_raw_c;
  end

  // Next half-period for the ramp; one extra bit keeps add/subtract from wrapping
  logic [CNT_W-1:0] rem_c;
  logic [DIV_W:0]   up_sum_c, dn_sub_c;
  logic [DIV_W-1:0] half_up_c, half_dn_c;
  always_comb begin
    rem_c     = cnt_lat - steps_done;
    up_sum_c  = {1'b0, cur_half} + {1'b0, ramp_lat};
    dn_sub_c  = {1'b0, cur_half} - {1'b0, ramp_lat};
    half_up_c = (up_sum_c > {1'b0, start_lat}) ? start_lat : DIV_W'(up_sum_c);
    half_dn_c = (dn_sub_c[DIV_W] || (DIV_W'(dn_sub_c) < target_lat)) ? target_lat
                                                                     : DIV_W'(dn_sub_c);
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt      = state;
    setup_cnt_nxt  = setup_cnt;
    phase_cnt_nxt  = phase_cnt;
    cur_half_nxt   = cur_half;
    ramp_cnt_nxt   = ramp_cnt;
    cnt_lat_nxt    = cnt_lat;
    start_lat_nxt  = start_lat;
    target_lat_nxt = target_lat;
    ramp_lat_nxt   = ramp_lat;
    abort_pend_nxt = abort_pend;
    step_nxt       = step;
    dir_nxt        = dir;
    busy_nxt       = busy;
    done_nxt       = 1'b0;
    aborted_nxt    = aborted;
    steps_done_nxt = steps_done;

    case (state)
      S_IDLE: begin
        if (start) begin
          steps_done_nxt = '0;
          aborted_nxt    = 1'b0;
          if (step_count == '0) begin
            state_nxt = S_FIN;
            done_nxt  = 1'b1;
          end else begin
            state_nxt      = S_SETUP;
            cnt_lat_nxt    = step_count;
            start_lat_nxt  = sh_clamp_c;
            target_lat_nxt = th_clamp_c;
            ramp_lat_nxt   = ramp_dec;
            cur_half_nxt   = sh_clamp_c;
            ramp_cnt_nxt   = '0;
            setup_cnt_nxt  = '0;
            abort_pend_nxt = 1'b0;
            dir_nxt        = dir_in;
            busy_nxt       = 1'b1;
          end
        end
      end

      S_SETUP: begin
        if (abort) begin
          state_nxt   = S_FIN;
          done_nxt    = 1'b1;
          busy_nxt    = 1'b0;
          aborted_nxt = 1'b1;
        end else if (setup_cnt == SETUP_LAST) begin
          state_nxt     = S_HIGH;
          step_nxt      = 1'b1;
          phase_cnt_nxt = '0;
        end else begin
          setup_cnt_nxt = setup_cnt + SET_W'(1);
        end
      end

      // An abort seen mid-pulse lets the pulse complete and counts it
      S_HIGH: begin
        if (abort) abort_pend_nxt = 1'b1;
        if (phase_cnt == cur_half - DIV_W'(1)) begin
          step_nxt       = 1'b0;
          phase_cnt_nxt  = '0;
          steps_done_nxt = steps_done + CNT_W'(1);
          if (abort || abort_pend) begin
            state_nxt   = S_FIN;
            done_nxt    = 1'b1;
            busy_nxt    = 1'b0;
            aborted_nxt = 1'b1;
          end else begin
            state_nxt = S_LOW;
          end
        end else begin
          phase_cnt_nxt = phase_cnt + DIV_W'(1);
        end
      end

      S_LOW: begin
        if (abort) begin
          state_nxt   = S_FIN;
          done_nxt    = 1'b1;
          busy_nxt    = 1'b0;
          aborted_nxt = 1'b1;
        end else if (phase_cnt == cur_half - DIV_W'(1)) begin
          phase_cnt_nxt = '0;
          if (steps_done == cnt_lat) begin
            state_nxt = S_FIN;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
          end else begin
            state_nxt = S_HIGH;
            step_nxt  = 1'b1;
            if (rem_c <= ramp_cnt) begin
              cur_half_nxt = half_up_c;
              ramp_cnt_nxt = (ramp_cnt == '0) ? '0 : ramp_cnt - CNT_W'(1);
            end else if (cur_half > target_lat) begin
              cur_half_nxt = half_dn_c;
              ramp_cnt_nxt = ramp_cnt + CNT_W'(1);
            end
          end
        end else begin
          phase_cnt_nxt = phase_cnt + DIV_W'(1);
        end
      end

      S_FIN: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
        step_nxt  = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      setup_cnt  <= '0;
      phase_cnt  <= '0;
      cur_half   <= '0;
      ramp_cnt   <= '0;
      cnt_lat    <= '0;
      start_lat  <= '0;
      target_lat <= '0;
      ramp_lat   <= '0;
      abort_pend <= 1'b0;
      step       <= 1'b0;
      dir        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      steps_done <= '0;
    end else begin
      state      <= state_nxt;
      setup_cnt  <= setup_cnt_nxt;
      phase_cnt  <= phase_cnt_nxt;
      cur_half   <= cur_half_nxt;
      ramp_cnt   <= ramp_cnt_nxt;
      cnt_lat    <= cnt_lat_nxt;
      start_lat  <= start_lat_nxt;
      target_lat <= target_lat_nxt;
      ramp_lat   <= ramp_lat_nxt;
      abort_pend <= abort_pend_nxt;
      step       <= step_nxt;
      dir        <= dir_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      aborted    <= aborted_nxt;
      steps_done <= steps_done_nxt;
    end
  end

endmodule

// File: tb/tb_stepper_pulse_gen.sv
// Directed bench for stepper_pulse_gen: pulse timing, ramps, abort, boundaries, reset.
module tb_stepper_pulse_gen;

  logic        clk = 1'b0;
  logic        rst, start, dir_in, abort;
  logic [31:0] step_count;
  logic [15:0] start_half, target_half, ramp_dec;
  logic        step, dir, busy, done, aborted;
  logic [31:0] steps_done;

  int checks = 0;
  int errors = 0;

  // Per-move observations filled in by capture()
  int highs[$];
  int lows[$];
  int first_rise, done_k, done_cnt;
  bit busy0, busy_ever, busy_pre, busy_done;

  stepper_pulse_gen #(.CNT_W(32), .DIV_W(16), .DIR_SETUP(4)) dut (
    .clk(clk), .rst(rst), .start(start), .step_count(step_count),
    .start_half(start_half), .target_half(target_half), .ramp_dec(ramp_dec),
    .dir_in(dir_in), .abort(abort), .step(step), .dir(dir), .busy(busy),
    .done(done), .aborted(aborted), .steps_done(steps_done)
  );

  always #5 clk = ~clk;

  task automatic launch(input int cnt, input int sh, input int th, input int rd, input bit d);
    step_count  = 32'(cnt);
    start_half  = 16'(sh);
    target_half = 16'(th);
    ramp_dec    = 16'(rd);
    dir_in      = d;
    start       = 1'b1;
    @(posedge clk); #1;
    start       = 1'b0;
  endtask

  // Samples 1 time unit after each edge; k=0 is right after the start edge
  task automatic capture(input int budget, input int abort_k, input int abort_len, input int restart_k);
    int hl, ll;
    bit prev;
    highs.delete(); lows.delete();
    first_rise = -1; done_k = -1; done_cnt = 0;
    busy0 = 0; busy_ever = 0; busy_pre = 0; busy_done = 1;
    hl = 0; ll = 0; prev = 0;
    for (int k = 0; k < budget; k++) begin
      if (k == abort_k) abort = 1'b1;
      if (k == abort_k + abort_len) abort = 1'b0;
      if (k == restart_k) begin start = 1'b1; step_count = 32'd20; end
      else if (k == restart_k + 1) start = 1'b0;
      if (k == 0) busy0 = busy;
      if (busy) busy_ever = 1;
      if (step) begin
        if (!prev) begin
          if (first_rise < 0) first_rise = k;
          else lows.push_back(ll);
        end
        hl++;
      end else begin
        if (prev) begin highs.push_back(hl); hl = 0; ll = 0; end
        ll++;
      end
      if (done) begin
        done_cnt++;
        if (done_k < 0) begin done_k = k; busy_done = busy; end
      end else if (done_k < 0) begin
        busy_pre = busy;
      end
      prev = step;
      if (done_k >= 0 && k >= done_k + 3) break;
      @(posedge clk); #1;
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; abort = 1'b0; dir_in = 1'b0;
    step_count = '0; start_half = '0; target_half = '0; ramp_dec = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL reset_step: got %b expected 0", step); end
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL reset_dir: got %b expected 0", dir); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL reset_aborted: got %b expected 0", aborted); end
    checks++; if (steps_done !== 32'd0) begin errors++; $display("FAIL reset_steps_done: got %0d expected 0", steps_done); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_constant_speed;
    launch(5, 10, 10, 0, 1'b1);
    capture(400, -1, 0, -1);
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL const_busy_after_start: got %b expected 1", busy0); end
    checks++; if (dir !== 1'b1) begin errors++; $display("FAIL const_dir: got %b expected 1", dir); end
    checks++; if (first_rise != 4) begin errors++; $display("FAIL const_first_rise: got %0d expected 4", first_rise); end
    checks++; if (highs.size() != 5) begin errors++; $display("FAIL const_pulses: got %0d expected 5", highs.size()); end
    for (int i = 0; i < 5; i++) begin
      int v;
      v = (i < highs.size()) ? highs[i] : -1;
      checks++; if (v != 10) begin errors++; $display("FAIL const_high[%0d]: got %0d expected 10", i, v); end
    end
    for (int i = 0; i < 4; i++) begin
      int v;
      v = (i < lows.size()) ? lows[i] : -1;
      checks++; if (v != 10) begin errors++; $display("FAIL const_low[%0d]: got %0d expected 10", i, v); end
    end
    checks++; if (done_k != 104) begin errors++; $display("FAIL const_done_time: got %0d expected 104", done_k); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL const_done_count: got %0d expected 1", done_cnt); end
    checks++; if (busy_pre !== 1'b1 || busy_done !== 1'b0) begin errors++; $display("FAIL const_busy_edges: got pre=%b at_done=%b expected 1/0", busy_pre, busy_done); end
    checks++; if (steps_done !== 32'd5) begin errors++; $display("FAIL const_steps_done: got %0d expected 5", steps_done); end
    checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL const_aborted: got %b expected 0", aborted); end
  endtask

  task automatic test_ramp;
    int exp_h[10] = '{8, 6, 4, 4, 4, 4, 4, 4, 6, 8};
    launch(10, 8, 4, 2, 1'b0);
    capture(400, -1, 0, -1);
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL ramp_dir: got %b expected 0", dir); end
    checks++; if (highs.size() != 10) begin errors++; $display("FAIL ramp_pulses: got %0d expected 10", highs.size()); end
    for (int i = 0; i < 10; i++) begin
      int v;
      v = (i < highs.size()) ? highs[i] : -1;
      checks++; if (v != exp_h[i]) begin errors++; $display("FAIL ramp_high[%0d]: got %0d expected %0d", i, v, exp_h[i]); end
    end
    checks++; if (done_k != 108) begin errors++; $display("FAIL ramp_done_time: got %0d expected 108", done_k); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL ramp_done_count: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_triangle;
    int exp_h[3] = '{8, 6, 8};
    launch(3, 8, 2, 2, 1'b1);
    capture(200, -1, 0, -1);
    checks++; if (highs.size() != 3) begin errors++; $display("FAIL tri_pulses: got %0d expected 3", highs.size()); end
    for (int i = 0; i < 3; i++) begin
      int v;
      v = (i < highs.size()) ? highs[i] : -1;
      checks++; if (v != exp_h[i]) begin errors++; $display("FAIL tri_high[%0d]: got %0d expected %0d", i, v, exp_h[i]); end
    end
    checks++; if (done_k != 48) begin errors++; $display("FAIL tri_done_time: got %0d expected 48", done_k); end
  endtask

  task automatic test_abort_high;
    launch(10, 6, 6, 0, 1'b1);
    capture(300, 29, 20, -1);
    checks++; if (highs.size() != 3) begin errors++; $display("FAIL aborth_pulses: got %0d expected 3", highs.size()); end
    checks++; if (highs.size() == 3 && highs[2] != 6) begin errors++; $display("FAIL aborth_last_high: got %0d expected 6", highs[2]); end
    checks++; if (done_k != 34) begin errors++; $display("FAIL aborth_done_time: got %0d expected 34", done_k); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL aborth_done_count: got %0d expected 1", done_cnt); end
    checks++; if (aborted !== 1'b1) begin errors++; $display("FAIL aborth_aborted: got %b expected 1", aborted); end
    checks++; if (steps_done !== 32'd3) begin errors++; $display("FAIL aborth_steps_done: got %0d expected 3", steps_done); end
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL aborth_step_low: got %b expected 0", step); end
  endtask

  task automatic test_abort_low;
    launch(10, 6, 6, 0, 1'b0);
    capture(300, 11, 1, -1);
    checks++; if (done_k != 12) begin errors++; $display("FAIL abortl_done_time: got %0d expected 12", done_k); end
    checks++; if (highs.size() != 1) begin errors++; $display("FAIL abortl_pulses: got %0d expected 1", highs.size()); end
    checks++; if (aborted !== 1'b1) begin errors++; $display("FAIL abortl_aborted: got %b expected 1", aborted); end
    checks++; if (steps_done !== 32'd1) begin errors++; $display("FAIL abortl_steps_done: got %0d expected 1", steps_done); end
  endtask

  task automatic test_zero_steps;
    launch(0, 5, 5, 0, 1'b1);
    capture(50, -1, 0, -1);
    checks++; if (done_k != 0) begin errors++; $display("FAIL zero_done_time: got %0d expected 0", done_k); end
    checks++; if (busy_ever !== 1'b0) begin errors++; $display("FAIL zero_busy_seen: got %b expected 0", busy_ever); end
    checks++; if (highs.size() != 0 || first_rise != -1) begin errors++; $display("FAIL zero_pulses: got %0d expected 0", highs.size()); end
    checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL zero_aborted: got %b expected 0", aborted); end
    checks++; if (steps_done !== 32'd0) begin errors++; $display("FAIL zero_steps_done: got %0d expected 0", steps_done); end
  endtask

  task automatic test_start_while_busy;
    launch(3, 4, 4, 0, 1'b1);
    capture(200, -1, 0, 10);
    checks++; if (highs.size() != 3) begin errors++; $display("FAIL restart_pulses: got %0d expected 3", highs.size()); end
    checks++; if (done_k != 28) begin errors++; $display("FAIL restart_done_time: got %0d expected 28", done_k); end
    checks++; if (steps_done !== 32'd3) begin errors++; $display("FAIL restart_steps_done: got %0d expected 3", steps_done); end
  endtask

  task automatic test_zero_half;
    launch(4, 0, 0, 0, 1'b0);
    capture(100, -1, 0, -1);
    checks++; if (highs.size() != 4) begin errors++; $display("FAIL zhalf_pulses: got %0d expected 4", highs.size()); end
    for (int i = 0; i < 4; i++) begin
      int v;
      v = (i < highs.size()) ? highs[i] : -1;
      checks++; if (v != 1) begin errors++; $display("FAIL zhalf_high[%0d]: got %0d expected 1", i, v); end
    end
    for (int i = 0; i < 3; i++) begin
      int v;
      v = (i < lows.size()) ? lows[i] : -1;
      checks++; if (v != 1) begin errors++; $display("FAIL zhalf_low[%0d]: got %0d expected 1", i, v); end
    end
    checks++; if (done_k != 12) begin errors++; $display("FAIL zhalf_done_time: got %0d expected 12", done_k); end
  endtask

  task automatic test_target_above_start;
    launch(4, 3, 7, 1, 1'b1);
    capture(100, -1, 0, -1);
    checks++; if (highs.size() != 4) begin errors++; $display("FAIL tgt_pulses: got %0d expected 4", highs.size()); end
    for (int i = 0; i < 4; i++) begin
      int v;
      v = (i < highs.size()) ? highs[i] : -1;
      checks++; if (v != 3) begin errors++; $display("FAIL tgt_high[%0d]: got %0d expected 3", i, v); end
    end
    checks++; if (done_k != 28) begin errors++; $display("FAIL tgt_done_time: got %0d expected 28", done_k); end
  endtask

  task automatic test_reset_mid_move;
    bit saw_done;
    launch(5, 10, 10, 0, 1'b1);
    repeat (6) begin @(posedge clk); #1; end
    checks++; if (step !== 1'b1) begin errors++; $display("FAIL rstmid_in_high: got %b expected 1", step); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (step !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_outputs: got step=%b busy=%b expected 0/0", step, busy); end
    rst = 1'b0;
    saw_done = 0;
    repeat (6) begin
      if (done) saw_done = 1;
      @(posedge clk); #1;
    end
    checks++; if (saw_done) begin errors++; $display("FAIL rstmid_no_done: got 1 expected 0"); end
    launch(2, 3, 3, 0, 1'b0);
    capture(100, -1, 0, -1);
    checks++; if (highs.size() != 2 || done_k != 16) begin errors++; $display("FAIL rstmid_clean_move: got pulses=%0d done=%0d expected 2/16", highs.size(), done_k); end
    checks++; if (steps_done !== 32'd2 || aborted !== 1'b0) begin errors++; $display("FAIL rstmid_status: got steps=%0d aborted=%b expected 2/0", steps_done, aborted); end
  endtask

  initial begin
    test_reset();
    test_constant_speed();
    test_ramp();
    test_triangle();
    test_abort_high();
    test_abort_low();
    test_zero_steps();
    test_start_while_busy();
    test_zero_half();
    test_target_above_start();
    test_reset_mid_move();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stepper_pulse_gen.md
# stepper_pulse_gen

Parametrised step/direction pulse generator for one stepper axis, driven from AXI GPIO control registers. A start strobe launches a move of a programmed number of step pulses with a programmable half-period, an optional linear acceleration and deceleration ramp, a direction set-up delay, abort support and a one-cycle completion strobe. It sits between the GPIO register block and the stepper driver's STEP/DIR pins.

## Interface
- CNT_W, 32, width of step count and progress counter
- DIV_W, 16, width of half-period and ramp fields, in clk cycles
- DIR_SETUP, 4, clk cycles between the dir update and the first step rising edge; must be ≥1
- clk  input  1  system clock; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  single-cycle launch strobe; only honoured in IDLE
- step_count  input  CNT_W  steps to issue; latched on start
- start_half  input  DIV_W  initial (slowest) half-period; latched on start
- target_half  input  DIV_W  cruise (fastest) half-period; latched on start
- ramp_dec  input  DIV_W  half-period change per step; 0 means constant speed; latched on start
- dir_in  input  1  direction; latched on start
- abort  input  1  level-sensitive stop request
- step  output  1  STEP pin
- dir  output  1  DIR pin
- busy  output  1  high from the cycle after start until the cycle before done
- done  output  1  one-cycle completion strobe
- aborted  output  1  valid with done; 1 if the move was ended by abort
- steps_done  output  CNT_W  completed steps in the current or last move

## Operation
- States: IDLE, SETUP, HIGH, LOW, FIN.
- IDLE, start=1, step_count≠0:
  - latch all inputs; dir<=dir_in; steps_done<=0; aborted<=0; busy<=1.
  - Clamp: a zero half-period becomes 1. If target_half>start_half, target_half becomes start_half.
  - cur_half<=start_half; ramp_cnt<=0. Go to SETUP.
- IDLE, start=1, step_count=0: go to FIN; no step pulses; aborted=0.
- SETUP: hold for DIR_SETUP cycles, then go to HIGH.
- HIGH: step=1 for cur_half cycles. At the end, steps_done increments and the state goes to LOW.
- LOW: step=0 for cur_half cycles. At the end:
  - if steps_done=step_count, go to FIN;
  - otherwise update cur_half and go to HIGH.
- cur_half update, with rem = step_count − steps_done:
  - If rem ≤ ramp_cnt: decelerate. cur_half<=min(cur_half+ramp_dec, start_half); ramp_cnt decrements, saturating at 0.
  - Else if cur_half>target_half: accelerate. cur_half<=max(cur_half−ramp_dec, target_half); ramp_cnt increments.
  - Else: cruise, no change.
  - Use DIV_W+1-bit intermediates so the add and subtract never wrap.
- Abort, sampled each cycle while busy:
  - In SETUP or LOW: go to FIN on the next cycle.
  - In HIGH: finish the current high phase and count that step, then go to FIN, skipping LOW.
  - aborted<=1.
- FIN: done=1 and busy=0 for exactly one cycle, then IDLE. steps_done and aborted hold until the next start.
- start while not in IDLE is ignored. start and abort together in IDLE: start wins, and abort is then seen in SETUP.
- dir changes only on an accepted start, never mid-move.

## Timing
- Reset values: step=0, dir=0, busy=0, done=0, aborted=0, steps_done=0. State is IDLE.
- Reset mid-move: step drops to 0 on the edge where rst is sampled high.
- All outputs are registered.
- start sampled at edge t:
  - busy=1 and dir valid after edge t;
  - the first step rise follows DIR_SETUP cycles later, after edge t+DIR_SETUP.
- Constant speed with half-period H and N steps:
  - step period is 2H cycles;
  - done is asserted 2H·N cycles after the first rise.
- Minimum step period is 2 cycles (H=1).
- Zero-step move: done high in the cycle after start, busy never asserted.

## Test plan
- Constant speed: step_count=5, start_half=target_half=10, ramp_dec=0, DIR_SETUP=4 → 5 pulses each 10 high / 10 low; first rise 4 cycles after busy; done one cycle; steps_done=5; aborted=0.
- Ramp: step_count=10, start_half=8, target_half=4, ramp_dec=2 → high-phase lengths 8,6,4,4,4,4,4,4,6,8; done once.
- Short ramp, triangle profile: step_count=3, start_half=8, target_half=2, ramp_dec=2 → high-phase lengths 8,6,8.
- Abort mid-HIGH on step 3, H=6 → that high phase stays 6 cycles; step then held 0; done with aborted=1; steps_done=3. Abort in LOW → done next cycle.
- Boundaries:
  - step_count=0 → done next cycle, busy never high.
  - start while busy → ignored.
  - start_half=0 → behaves as H=1 (period 2).
  - target_half>start_half → constant start_half.
- rst asserted mid-HIGH → step=0 and busy=0 next cycle; no done; a new start then gives a clean move.
